// File: rtl/cpu_v3_pkg.sv
// Shared definitions for the V3 8-bit CPU: opcode constants, fetch-state encoding,
// default immediate-carrying opcode mask and IF/ID field widths.
package cpu_v3_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h9;
  localparam logic [OPC_W-1:0] OP_CALL = 4'hA;
  localparam logic [OPC_W-1:0] OP_RET  = 4'hB;
  localparam logic [OPC_W-1:0] OP_LDM  = 4'hC;

  // Bit n set means opcode group n is followed by an immediate byte.
  localparam logic [15:0] TWO_BYTE_MASK_DEFAULT = 16'h1400;

  typedef enum logic {
    FETCH_OP,
    FETCH_IMM
  } fetch_state_t;

  function automatic logic has_imm(input logic [15:0] mask, input logic [DATA_W-1:0] opcode);
    return mask[opcode[DATA_W-1 -: OPC_W]];
  endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Interrupt request edge detector: a rising edge of int_sig sets pending,
// clr drops it once the request has been injected into the pipeline.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic int_sig,
  input  logic clr,
  output logic pending
);

  logic int_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (rst) begin
      int_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      int_q <= int_sig;
      // A fresh edge wins over a same-cycle clear so no request is lost.
      if (int_sig && !int_q) pending <= 1'b1;
      else if (clr)          pending <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage of the V3 CPU: PC, 1/2-byte instruction assembly and IF/ID register.
// Define INT_VECTOR_EN to enable interrupt injection at instruction boundaries.
module instr_fetch_stage
  import cpu_v3_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC      = 8'h00,
  parameter logic [15:0]       TWO_BYTE_MASK = TWO_BYTE_MASK_DEFAULT,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR    = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              int_sig,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_imm,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic              ifid_int
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] op_hold_q, op_hold_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              int_q, int_d;
  logic              advance, int_pending, inject, op_is_long;

  assign advance    = !id_stall;
  assign pc_inc     = pc_q + 8'd1;
  assign op_is_long = has_imm(TWO_BYTE_MASK, imem_rdata);
  assign inject     = (state_q == FETCH_OP) && advance && !redirect_valid && int_pending;

`ifdef INT_VECTOR_EN
  int_edge_latch u_int_edge_latch (
    .clk     (clk),
    .rst     (rst),
    .int_sig (int_sig),
    .clr     (inject),
    .pending (int_pending)
  );
`else
  logic unused_int_sig;
  assign unused_int_sig = int_sig;
  assign int_pending    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_OP;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH_OP;
    end else if (advance) begin
      case (state_q)
        FETCH_OP:  if (!inject && op_is_long) state_d = FETCH_IMM;
        FETCH_IMM: state_d = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    op_hold_d = op_hold_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_next_d = pc_next_q;
    int_d     = int_q;
    if (redirect_valid) begin
      // A half-assembled opcode is abandoned simply by returning to FETCH_OP.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      int_d   = 1'b0;
    end else if (advance) begin
      case (state_q)
        FETCH_OP: begin
          if (inject) begin
            valid_d   = 1'b1;
            int_d     = 1'b1;
            instr_d   = '0;
            imm_d     = '0;
            pc_next_d = pc_q;
            pc_d      = IRQ_VECTOR;
          end else if (op_is_long) begin
            op_hold_d = imem_rdata;
            pc_d      = pc_inc;
            valid_d   = 1'b0;
            int_d     = 1'b0;
          end else begin
            valid_d   = 1'b1;
            int_d     = 1'b0;
            instr_d   = imem_rdata;
            imm_d     = '0;
            pc_next_d = pc_inc;
            pc_d      = pc_inc;
          end
        end
        FETCH_IMM: begin
          valid_d   = 1'b1;
          int_d     = 1'b0;
          instr_d   = op_hold_q;
          imm_d     = imem_rdata;
          pc_next_d = pc_inc;
          pc_d      = pc_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      // NOTE: op_hold is reset too; it is a single register, not a memory, and costs nothing to clear.
      op_hold_q <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      pc_next_q <= '0;
      int_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      op_hold_q <= op_hold_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      pc_next_q <= pc_next_d;
      int_q     <= int_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_instr   = instr_q;
  assign ifid_imm     = imm_q;
  assign ifid_pc_next = pc_next_q;
  assign ifid_int     = int_q;

endmodule
